reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised, clocked general-purpose register file for the KGP-RISC datapath.
//  Provides NUM_RD combinational read ports and one synchronous write port, with
//  write-to-read bypass, an optional hardwired zero register, and a per-register
//  pending-write scoreboard. Decode uses the scoreboard to stall on multicycle results.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W registers
//  NUM_RD    2   number of independent read ports (1..4)
//  ZERO_REG  1   1: register 0 always reads 0, ignores writes and pending-sets
//  BYPASS    1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous active-low reset
//  wr_en      in   1               write strobe, sampled at posedge clk
//  wr_addr    in   ADDR_W          write address
//  wr_data    in   DATA_W          write data
//  rd_addr    in   NUM_RD*ADDR_W   read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*DATA_W   read data; port k = bits [k*DATA_W +: DATA_W]
//  rd_busy    out  NUM_RD          1 = register addressed by port k has a pending write
//  set_en     in   1               mark set_addr pending (long-latency op issued)
//  set_addr   in   ADDR_W          register to mark pending
//  flush      in   1               synchronous clear of all pending bits
//  any_busy   out  1               OR of all pending bits
// BEHAVIOUR
//  Reset: rst_n low asynchronously clears all 2**ADDR_W registers and all pending
//   bits to 0; rd_data then reads 0 on every port, rd_busy = 0, any_busy = 0.
//  Write: at posedge clk with wr_en=1 and rst_n=1, regs[wr_addr] <= wr_data.
//   If ZERO_REG=1 and wr_addr=0 the write is dropped.
//  Read: combinational, zero latency. rd_data[k] = regs[rd_addr[k]], except:
//   - ZERO_REG=1 and rd_addr[k]=0 -> 0 (overrides bypass).
//   - BYPASS=1, wr_en=1, wr_addr=rd_addr[k] (and not zero reg) -> wr_data.
//   - BYPASS=0 -> old value this cycle, new value the cycle after the edge.
//  Multiple read ports may address the same register; each gets identical data.
//  Scoreboard, per register i, updated at posedge clk, priority high->low:
//   1. flush=1                          -> pend[i] <= 0 (overrides set and write)
//   2. set_en=1 and set_addr=i          -> pend[i] <= 1 (new issue wins over clear)
//   3. wr_en=1 and wr_addr=i            -> pend[i] <= 0
//   4. otherwise hold.
//   ZERO_REG=1: pend[0] is constant 0; set_en on address 0 is ignored.
//  rd_busy[k] = pend[rd_addr[k]] AND NOT (BYPASS=1, wr_en=1, wr_addr=rd_addr[k]):
//   a completing write in the same cycle unblocks the reader, consistent with bypass.
//  any_busy = OR of pend[], registered state only (no bypass term).
//  Writes to an address whose pend bit is 0 are legal; data updates, pend stays 0.
//  rst_n asserted mid-operation: state clears immediately; the in-flight edge's
//   write and set are lost. Deassertion takes effect from the next posedge.
//  Widths: no arithmetic; addresses index modulo 2**ADDR_W by construction.
// TESTING
//  1 Reset: load regs 1..31 = index, pulse rst_n low mid-cycle -> all rd_data=0
//    immediately, rd_busy=0, any_busy=0.
//  2 Zero reg: wr_en, wr_addr=0, wr_data=32'hDEADBEEF; read addr 0 on both ports ->
//    0, same and next cycle; set_en addr 0 -> rd_busy=0, any_busy=0.
//  3 Bypass: regs[5]=32'h11; wr_en addr5 data 32'h22, rd_addr0=rd_addr1=5 same cycle
//    -> both 32'h22 (BYPASS=1); rebuild BYPASS=0 -> 32'h11, then 32'h22 after edge.
//  4 Scoreboard: set_en addr 7 -> next cycle rd_busy for port reading 7 =1, any_busy=1;
//    wr_en addr 7 data 32'hA5 -> rd_busy 0 that cycle with rd_data 32'hA5; pend clear after.
//  5 Simultaneous: set_en and wr_en both addr 9 -> pend[9]=1 after edge; then set_en
//    addr 9 with flush=1 -> pend[9]=0, any_busy=0.
//  6 Random: 10k cycles random wr/set/flush/addrs on NUM_RD=3, ADDR_W=4 vs
//    reference model; compare rd_data, rd_busy, any_busy every cycle.

Source files
------------

// File: rtl/reg_file_sb.sv
// General-purpose register file with combinational read ports,
// write-to-read bypass, optional zero register and pending-write scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       set_en,
  input  logic [ADDR_W-1:0]          set_addr,
  input  logic                       flush,
  output logic                       any_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pendNext;
  logic              wrZero;
  logic              setZero;
  logic              wrOk;
  logic              setOk;

  assign wrZero  = (ZERO_REG != 0) && (wr_addr == '0);
  assign setZero = (ZERO_REG != 0) && (set_addr == '0);
  assign wrOk    = wr_en && !wrZero;
  assign setOk   = set_en && !setZero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wrOk) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A new issue to the same register wins over the completing write.
  always_comb begin
    pendNext = pend;
    if (wrOk) begin
      pendNext[wr_addr] = 1'b0;
    end
    if (setOk) begin
      pendNext[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (flush) begin
      pend <= '0;
    end else begin
      pend <= pendNext;
    end
  end

  assign any_busy = |pend;

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              isZero;
    logic              hit;

    assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
    assign isZero = (ZERO_REG != 0) && (addr == '0);
    assign hit    = (BYPASS != 0) && wr_en &&
                    (wr_addr == addr) && !isZero;

    always_comb begin
      unique case (1'b1)
        isZero:  data = '0;
        hit:     data = wr_data;
        default: data = regs[addr];
      endcase
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k] = pend[addr] && !hit;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomised checks of reg_file_sb against
// constants and a reference model, via an expectation queue.
module tb_reg_file_sb;

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic        wrEn = 1'b0;
  logic [4:0]  wrAddr = '0;
  logic [31:0] wrData = '0;
  logic [9:0]  rdAddr = '0;
  logic        setEn = 1'b0;
  logic [4:0]  setAddr = '0;
  logic        flush = 1'b0;

  logic [63:0] rdDataA, rdDataB;
  logic [1:0]  rdBusyA, rdBusyB;
  logic        anyBusyA, anyBusyB;

  logic        rWrEn = 1'b0;
  logic [3:0]  rWrAddr = '0;
  logic [31:0] rWrData = '0;
  logic [11:0] rRdAddr = '0;
  logic        rSetEn = 1'b0;
  logic [3:0]  rSetAddr = '0;
  logic        rFlush = 1'b0;
  logic [95:0] rRdData;
  logic [2:0]  rRdBusy;
  logic        rAnyBusy;

  reg_file_sb #(.BYPASS(1)) dutA (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_addr(rdAddr), .rd_data(rdDataA), .rd_busy(rdBusyA),
    .set_en(setEn), .set_addr(setAddr), .flush(flush),
    .any_busy(anyBusyA)
  );

  reg_file_sb #(.BYPASS(0)) dutB (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_addr(rdAddr), .rd_data(rdDataB), .rd_busy(rdBusyB),
    .set_en(setEn), .set_addr(setAddr), .flush(flush),
    .any_busy(anyBusyB)
  );

  reg_file_sb #(.ADDR_W(4), .NUM_RD(3)) dutR (
    .clk(clk), .rst_n(rst_n),
    .wr_en(rWrEn), .wr_addr(rWrAddr), .wr_data(rWrData),
    .rd_addr(rRdAddr), .rd_data(rRdData), .rd_busy(rRdBusy),
    .set_en(rSetEn), .set_addr(rSetAddr), .flush(rFlush),
    .any_busy(rAnyBusy)
  );

  task automatic push(input string t, input logic [127:0] v);
    sbq.push_back('{t, v});
  endtask

  task automatic check(input logic [127:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] mR [16];
  logic [15:0] mP;
  logic [95:0] eData;
  logic [2:0]  eBusy;
  logic [3:0]  a;

  initial begin
    for (int i = 0; i < 16; i++) mR[i] = '0;
    mP = '0;
    #12 rst_n = 1'b1;

    // 1: load, mark one pending, then async reset mid-cycle
    for (int i = 1; i < 32; i++) begin
      step();
      wrEn = 1'b1; wrAddr = 5'(i); wrData = 32'(i);
    end
    step();
    wrEn = 1'b0; setEn = 1'b1; setAddr = 5'd4;
    rdAddr = {5'd31, 5'd3};
    push("load_rd", 128'({32'd31, 32'd3}));
    #1 check(128'(rdDataA));
    step();
    setEn = 1'b0; rdAddr = {5'd4, 5'd4};
    push("pre_rst_busy", 128'(2'b11));
    push("pre_rst_any", 128'(1'b1));
    #1 check(128'(rdBusyA));
    check(128'(anyBusyA));
    #1 rst_n = 1'b0;
    rdAddr = {5'd31, 5'd3};
    push("rst_rd_a", 128'(0));
    push("rst_rd_b", 128'(0));
    push("rst_busy", 128'(0));
    push("rst_any", 128'(0));
    #1 check(128'(rdDataA));
    check(128'(rdDataB));
    check(128'(rdBusyA));
    check(128'(anyBusyA));
    @(negedge clk) rst_n = 1'b1;

    // 2: zero register
    step();
    wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hDEADBEEF;
    setEn = 1'b1; setAddr = 5'd0; rdAddr = '0;
    push("zero_same_a", 128'(0));
    push("zero_same_b", 128'(0));
    #1 check(128'(rdDataA));
    check(128'(rdDataB));
    step();
    wrEn = 1'b0; setEn = 1'b0;
    push("zero_next", 128'(0));
    push("zero_busy", 128'(0));
    push("zero_any", 128'(0));
    #1 check(128'(rdDataA));
    check(128'(rdBusyA));
    check(128'(anyBusyA));

    // 3: bypass versus no bypass
    step();
    wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'h11;
    step();
    wrData = 32'h22; rdAddr = {5'd5, 5'd5};
    push("byp_on", 128'({32'h22, 32'h22}));
    push("byp_off", 128'({32'h11, 32'h11}));
    #1 check(128'(rdDataA));
    check(128'(rdDataB));
    step();
    wrEn = 1'b0;
    push("byp_off_next", 128'({32'h22, 32'h22}));
    #1 check(128'(rdDataB));

    // 4: scoreboard set then completing write
    step();
    setEn = 1'b1; setAddr = 5'd7; rdAddr = {5'd7, 5'd5};
    push("sb_set_busy", 128'(0));
    push("sb_set_any", 128'(0));
    #1 check(128'(rdBusyA));
    check(128'(anyBusyA));
    step();
    setEn = 1'b0;
    push("sb_pend_busy", 128'(2'b10));
    push("sb_pend_any", 128'(1'b1));
    #1 check(128'(rdBusyA));
    check(128'(anyBusyA));
    step();
    wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hA5;
    push("sb_wr_busy", 128'(0));
    push("sb_wr_data", 128'({32'hA5, 32'h22}));
    push("sb_wr_busy_nb", 128'(2'b10));
    push("sb_wr_any", 128'(1'b1));
    #1 check(128'(rdBusyA));
    check(128'(rdDataA));
    check(128'(rdBusyB));
    check(128'(anyBusyA));
    step();
    wrEn = 1'b0;
    push("sb_clr_busy", 128'(0));
    push("sb_clr_any", 128'(0));
    #1 check(128'(rdBusyA));
    check(128'(anyBusyA));

    // 5: set+write same reg, then set under flush
    step();
    wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h99;
    setEn = 1'b1; setAddr = 5'd9; rdAddr = {5'd9, 5'd9};
    step();
    wrEn = 1'b0; setEn = 1'b0;
    push("sim_busy", 128'(2'b11));
    push("sim_any", 128'(1'b1));
    push("sim_data", 128'({32'h99, 32'h99}));
    #1 check(128'(rdBusyA));
    check(128'(anyBusyA));
    check(128'(rdDataA));
    step();
    setEn = 1'b1; flush = 1'b1;
    step();
    setEn = 1'b0; flush = 1'b0;
    push("flush_busy", 128'(0));
    push("flush_any", 128'(0));
    #1 check(128'(rdBusyA));
    check(128'(anyBusyA));

    // 6: random traffic on the 3-port, 16-entry instance
    for (int c = 0; c < 10000; c++) begin
      step();
      rWrEn    = 1'($urandom_range(0, 1));
      rWrAddr  = 4'($urandom);
      rWrData  = $urandom;
      rRdAddr  = 12'($urandom);
      if ($urandom_range(0, 3) == 0) rRdAddr[3:0] = rWrAddr;
      rSetEn   = 1'($urandom_range(0, 1));
      rSetAddr = 4'($urandom);
      rFlush   = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 3; k++) begin
        a = rRdAddr[k*4 +: 4];
        if (a == 4'd0) eData[k*32 +: 32] = '0;
        else if (rWrEn && rWrAddr == a) eData[k*32 +: 32] = rWrData;
        else eData[k*32 +: 32] = mR[a];
        eBusy[k] = mP[a] && !(rWrEn && rWrAddr == a && a != 4'd0);
      end
      push("rnd_data", 128'(eData));
      push("rnd_busy", 128'(eBusy));
      push("rnd_any", 128'(|mP));
      #1 check(128'(rRdData));
      check(128'(rRdBusy));
      check(128'(rAnyBusy));
      if (rFlush) mP = '0;
      else begin
        if (rWrEn && rWrAddr != 4'd0) mP[rWrAddr] = 1'b0;
        if (rSetEn && rSetAddr != 4'd0) mP[rSetAddr] = 1'b1;
      end
      if (rWrEn && rWrAddr != 4'd0) mR[rWrAddr] = rWrData;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
